// File: rtl/ex_mem_skid_stage_pkg.sv
// EX->MEM skid stage shared definitions.
// Default widths, FSM encodings, occupancy next-state helper.
package ex_mem_skid_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int WB_W_DEF   = 2;
  localparam int M_W_DEF    = 3;
  localparam int RD_W_DEF   = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Occupancy update ignoring flush/reset.
  function automatic logic [1:0] st_next(
    input logic [1:0] st,
    input logic       in_fire,
    input logic       out_fire
  );
    logic [1:0] nx;
    nx = ST_EMPTY;
    case (st)
      ST_EMPTY: nx = in_fire ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (in_fire && !out_fire)
          nx = ST_FULL;
        else if (!in_fire && out_fire)
          nx = ST_EMPTY;
        else
          nx = ST_ONE;
      end
      ST_FULL: nx = out_fire ? ST_ONE : ST_FULL;
      default: nx = ST_EMPTY;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM entry bus with valid/ready handshake.
// master drives the entry, slave returns ready.
interface ex_mem_skid_stage_if
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int RD_W   = RD_W_DEF
);

  logic              valid;
  logic              ready;
  logic [WB_W-1:0]   wb;
  logic [M_W-1:0]    m;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] tgt;
  logic              zero;
  logic [DATA_W-1:0] sdata;
  logic [RD_W-1:0]   rd;

  modport master (
    output valid, wb, m, alu, tgt, zero, sdata, rd,
    input  ready
  );

  modport slave (
    input  valid, wb, m, alu, tgt, zero, sdata, rd,
    output ready
  );

endinterface

// File: rtl/ex_mem_skid_stage_pipe_slot.sv
// One EX/MEM entry register (ctrl + data fields).
// Separate clears let flush kill ctrl and optionally data.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic              clr_data_i,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [M_W-1:0]    m_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] tgt_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [M_W-1:0]    m_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] tgt_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] sdata_o,
  output logic [RD_W-1:0]   rd_o
);

  logic [WB_W-1:0]   wb_q;
  logic [M_W-1:0]    m_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] tgt_q;
  logic              zero_q;
  logic [DATA_W-1:0] sdata_q;
  logic [RD_W-1:0]   rd_q;

  // Load entry; clears win over load, reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q    <= '0;
      m_q     <= '0;
      alu_q   <= '0;
      tgt_q   <= '0;
      zero_q  <= 1'b0;
      sdata_q <= '0;
      rd_q    <= '0;
    end else begin
      if (load_i) begin
        wb_q    <= wb_i;
        m_q     <= m_i;
        alu_q   <= alu_i;
        tgt_q   <= tgt_i;
        zero_q  <= zero_i;
        sdata_q <= sdata_i;
        rd_q    <= rd_i;
      end
      if (clr_ctrl_i) begin
        wb_q <= '0;
        m_q  <= '0;
      end
      if (clr_data_i) begin
        alu_q   <= '0;
        tgt_q   <= '0;
        zero_q  <= 1'b0;
        sdata_q <= '0;
        rd_q    <= '0;
      end
    end
  end

  assign wb_o    = wb_q;
  assign m_o     = m_q;
  assign alu_o   = alu_q;
  assign tgt_o   = tgt_q;
  assign zero_o  = zero_q;
  assign sdata_o = sdata_q;
  assign rd_o    = rd_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with 2-entry skid buffer.
// Registered in_ready; main slot drives MEM, skid absorbs stalls.
module ex_mem_skid_stage
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WB_W       = WB_W_DEF,
  parameter int M_W        = M_W_DEF,
  parameter int RD_W       = RD_W_DEF,
  parameter bit FLUSH_DATA = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush,
  ex_mem_skid_stage_if.slave   ex_i,
  ex_mem_skid_stage_if.master  mem_o
);

  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       in_fire, out_fire;
  logic       main_ld, skid_ld, main_from_skid;
  logic       clr_data;

  logic [WB_W-1:0]   skid_wb,    main_wb_d;
  logic [M_W-1:0]    skid_m,     main_m_d;
  logic [DATA_W-1:0] skid_alu,   main_alu_d;
  logic [DATA_W-1:0] skid_tgt,   main_tgt_d;
  logic              skid_zero,  main_zero_d;
  logic [DATA_W-1:0] skid_sdata, main_sdata_d;
  logic [RD_W-1:0]   skid_rd,    main_rd_d;

  assign in_fire  = ex_i.valid & in_ready_q;
  assign out_fire = mem_o.valid & mem_o.ready;
  assign clr_data = flush & FLUSH_DATA;

  assign ex_i.ready  = in_ready_q;
  assign mem_o.valid = (state_q != ST_EMPTY);

  // Occupancy FSM and slot load decisions; flush kills everything.
  always_comb begin
    state_d        = st_next(state_q, in_fire, out_fire);
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: main_ld = in_fire;
      ST_ONE: begin
        main_ld = in_fire & out_fire;
        skid_ld = in_fire & ~out_fire;
      end
      ST_FULL: begin
        main_ld        = out_fire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // Main slot source: skid on drain from FULL, else EX.
  always_comb begin
    main_wb_d    = ex_i.wb;
    main_m_d     = ex_i.m;
    main_alu_d   = ex_i.alu;
    main_tgt_d   = ex_i.tgt;
    main_zero_d  = ex_i.zero;
    main_sdata_d = ex_i.sdata;
    main_rd_d    = ex_i.rd;
    if (main_from_skid) begin
      main_wb_d    = skid_wb;
      main_m_d     = skid_m;
      main_alu_d   = skid_alu;
      main_tgt_d   = skid_tgt;
      main_zero_d  = skid_zero;
      main_sdata_d = skid_sdata;
      main_rd_d    = skid_rd;
    end
  end

  // State and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W), .WB_W(WB_W), .M_W(M_W), .RD_W(RD_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load_i    (main_ld),
    .clr_ctrl_i(flush),
    .clr_data_i(clr_data),
    .wb_i      (main_wb_d),
    .m_i       (main_m_d),
    .alu_i     (main_alu_d),
    .tgt_i     (main_tgt_d),
    .zero_i    (main_zero_d),
    .sdata_i   (main_sdata_d),
    .rd_i      (main_rd_d),
    .wb_o      (mem_o.wb),
    .m_o       (mem_o.m),
    .alu_o     (mem_o.alu),
    .tgt_o     (mem_o.tgt),
    .zero_o    (mem_o.zero),
    .sdata_o   (mem_o.sdata),
    .rd_o      (mem_o.rd)
  );

  pipe_slot #(
    .DATA_W(DATA_W), .WB_W(WB_W), .M_W(M_W), .RD_W(RD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (skid_ld),
    .clr_ctrl_i(flush),
    .clr_data_i(clr_data),
    .wb_i      (ex_i.wb),
    .m_i       (ex_i.m),
    .alu_i     (ex_i.alu),
    .tgt_i     (ex_i.tgt),
    .zero_i    (ex_i.zero),
    .sdata_i   (ex_i.sdata),
    .rd_i      (ex_i.rd),
    .wb_o      (skid_wb),
    .m_o       (skid_m),
    .alu_o     (skid_alu),
    .tgt_o     (skid_tgt),
    .zero_o    (skid_zero),
    .sdata_o   (skid_sdata),
    .rd_o      (skid_rd)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: scoreboard plus directed checks.
// dut0 keeps data on flush, dut1 zeroes it.
module tb_ex_mem_skid_stage;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;
  logic [31:0]  cur;
  logic [106:0] sb[$];
  logic [106:0] o0, o1, e;

  ex_mem_skid_stage_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) ex0 ();
  ex_mem_skid_stage_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) mem0 ();
  ex_mem_skid_stage_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) ex1 ();
  ex_mem_skid_stage_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) mem1 ();

  ex_mem_skid_stage #(
    .DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5), .FLUSH_DATA(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .ex_i(ex0), .mem_o(mem0)
  );

  ex_mem_skid_stage #(
    .DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5), .FLUSH_DATA(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .ex_i(ex1), .mem_o(mem1)
  );

  assign o0 = {mem0.wb, mem0.m, mem0.alu, mem0.tgt,
               mem0.zero, mem0.sdata, mem0.rd};
  assign o1 = {mem1.wb, mem1.m, mem1.alu, mem1.tgt,
               mem1.zero, mem1.sdata, mem1.rd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [106:0] pk(input logic [31:0] x);
    return {x[1:0], x[2:0], x, x ^ 32'hFFFF_0000, x[0], ~x, x[4:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [31:0] x);
    cur       = x;
    ex0.valid = v;  ex1.valid = v;
    ex0.alu   = x;  ex1.alu   = x;
    ex0.tgt   = x ^ 32'hFFFF_0000;
    ex1.tgt   = x ^ 32'hFFFF_0000;
    ex0.sdata = ~x; ex1.sdata = ~x;
    ex0.zero  = x[0];   ex1.zero = x[0];
    ex0.rd    = x[4:0]; ex1.rd   = x[4:0];
    ex0.wb    = x[1:0]; ex1.wb   = x[1:0];
    ex0.m     = x[2:0]; ex1.m    = x[2:0];
  endtask

  task automatic ordy(input logic v);
    mem0.ready = v;
    mem1.ready = v;
  endtask

  task automatic tick();
    logic [106:0] ex;
    #3;
    if (rst) begin
      sb.delete();
    end else begin
      if (mem0.valid && mem0.ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_spurious obs=%0h exp=none", mem0.alu);
        end
        if (sb.size() != 0) begin
          ex = sb.pop_front();
          chk("sb_entry", 128'(o0), 128'(ex));
        end
      end
      if (flush)
        sb.delete();
      else if (ex0.valid && ex0.ready)
        sb.push_back(pk(cur));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    ordy(1'b0);
    put(1'b0, 32'h0);

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", 128'(mem0.valid), 128'(1'b0));
    chk("rst_ready0", 128'(ex0.ready), 128'(1'b1));
    chk("rst_out0", 128'(o0), 128'(0));
    chk("rst_out1", 128'(o1), 128'(0));
    rst = 1'b0;

    // 2: streaming
    ordy(1'b1);
    put(1'b1, 32'd1);
    tick();
    chk("str_lat1", 128'(mem0.alu), 128'(32'd1));
    chk("str_rdy1", 128'(ex0.ready), 128'(1'b1));
    put(1'b1, 32'd2);
    tick();
    chk("str_rdy2", 128'(ex0.ready), 128'(1'b1));
    put(1'b1, 32'd3);
    tick();
    chk("str_rdy3", 128'(ex0.ready), 128'(1'b1));
    chk("str_alu3", 128'(mem0.alu), 128'(32'd3));
    put(1'b0, 32'd0);
    tick();
    chk("str_empty", 128'(mem0.valid), 128'(1'b0));
    chk("str_drain", 128'(sb.size()), 128'(0));

    // 3: stall into FULL, then drain
    ordy(1'b0);
    put(1'b1, 32'hA);
    tick();
    put(1'b1, 32'hB);
    tick();
    chk("stl_valid", 128'(mem0.valid), 128'(1'b1));
    chk("stl_alu", 128'(mem0.alu), 128'(32'hA));
    chk("stl_rdy", 128'(ex0.ready), 128'(1'b0));
    put(1'b1, 32'hC);
    tick();
    chk("stl_hold", 128'(mem0.alu), 128'(32'hA));
    chk("stl_rdy_h", 128'(ex0.ready), 128'(1'b0));
    put(1'b0, 32'h0);
    ordy(1'b1);
    tick();
    chk("drn_alu", 128'(mem0.alu), 128'(32'hB));
    chk("drn_rdy", 128'(ex0.ready), 128'(1'b1));
    tick();
    chk("drn_empty", 128'(mem0.valid), 128'(1'b0));
    chk("drn_sb", 128'(sb.size()), 128'(0));

    // 4/5: flush while FULL with an entry presented
    ordy(1'b0);
    put(1'b1, 32'h13);
    tick();
    put(1'b1, 32'h17);
    tick();
    chk("fl_full", 128'(ex0.ready), 128'(1'b0));
    put(1'b1, 32'h1F);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(1'b0, 32'h0);
    chk("fl_valid0", 128'(mem0.valid), 128'(1'b0));
    chk("fl_valid1", 128'(mem1.valid), 128'(1'b0));
    chk("fl_rdy0", 128'(ex0.ready), 128'(1'b1));
    chk("fl_rdy1", 128'(ex1.ready), 128'(1'b1));
    e = pk(32'h13);
    e[106:102] = 5'b0;
    chk("fl_keep0", 128'(o0), 128'(e));
    chk("fl_zero1", 128'(o1), 128'(0));
    ordy(1'b1);
    tick();
    chk("fl_gone_a", 128'(mem0.valid), 128'(1'b0));
    tick();
    chk("fl_gone_b", 128'(mem0.valid), 128'(1'b0));
    put(1'b1, 32'h21);
    tick();
    chk("fl_new", 128'(o0), 128'(pk(32'h21)));
    put(1'b0, 32'h0);
    tick();
    chk("fl_sb", 128'(sb.size()), 128'(0));
    chk("fl_end", 128'(mem0.valid), 128'(1'b0));

    // reset while FULL drops both entries
    ordy(1'b0);
    put(1'b1, 32'h41);
    tick();
    put(1'b1, 32'h42);
    tick();
    chk("rf_full", 128'(ex0.ready), 128'(1'b0));
    rst = 1'b1;
    put(1'b0, 32'h0);
    tick();
    rst = 1'b0;
    chk("rf_valid", 128'(mem0.valid), 128'(1'b0));
    chk("rf_rdy", 128'(ex0.ready), 128'(1'b1));
    chk("rf_out", 128'(o0), 128'(0));
    ordy(1'b1);
    tick();
    put(1'b1, 32'h44);
    tick();
    put(1'b0, 32'h0);
    tick();
    chk("rf_sb", 128'(sb.size()), 128'(0));

    // 6: rst with in_valid and flush in ONE
    ordy(1'b0);
    put(1'b1, 32'h35);
    tick();
    chk("r6_one", 128'(mem0.valid), 128'(1'b1));
    rst   = 1'b1;
    flush = 1'b1;
    put(1'b1, 32'h3A);
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    put(1'b0, 32'h0);
    chk("r6_valid0", 128'(mem0.valid), 128'(1'b0));
    chk("r6_valid1", 128'(mem1.valid), 128'(1'b0));
    chk("r6_rdy", 128'(ex0.ready), 128'(1'b1));
    chk("r6_out0", 128'(o0), 128'(0));
    chk("r6_out1", 128'(o1), 128'(0));
    ordy(1'b1);
    tick();
    chk("r6_gone", 128'(mem0.valid), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
